link_sample_sequencer: RTL and testbench

Sequences the sample path of the point-to-point link, on the sender side and the receiver side.
- Arms on the sender sync input and generates the sample grid: one tick every SAMPLE_PERIOD clocks.
- Captures the ADC word on each tick and hands it to the link transmitter over a valid/ready handshake.
- Re-times received words onto the same grid so the DA output changes only on ticks.
- Sits between the ADC/DAC pins and the link TX/RX cores, inside the connect wrapper.

---
 rtl/link_pkg.sv | 29 ++
 rtl/sample_tick_gen.sv | 45 ++++
 rtl/link_sample_sequencer.sv | 171 +++++++++++++++++
 tb/tb_link_sample_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/link_pkg.sv
// link_pkg: shared definitions for the link sample sequencer.
//   link_state_t  : sequencer FSM state encoding (IDLE/ARM/RUN/DRAIN)
//   DEFAULT_*     : default sample period and sample width
//   cnt_width()   : bits needed for a counter holding values 0..n-1
package link_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } link_state_t;

    localparam int DEFAULT_SAMPLE_PERIOD = 720;
    localparam int DEFAULT_DATA_WIDTH    = 8;

    // ceil(log2(n)), never less than one bit so degenerate sizes still elaborate.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// sample_tick_gen: free-running period counter with a one-cycle tick at count 0.
//   clock  : system clock
//   reset  : synchronous active-high reset
//   enable : counter advances while high
//   clear  : holds the counter at 0 (takes priority over enable)
//   tick   : high while enabled and the counter is at 0
// Because the counter sits at 0 while cleared, the first enabled cycle ticks.
module sample_tick_gen
    import link_pkg::*;
#(
    parameter int PERIOD = DEFAULT_SAMPLE_PERIOD
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = cnt_width(PERIOD);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (enable) begin
            count_next = (count_reg == LAST) ? '0 : count_reg + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign tick = enable && !clear && (count_reg == '0);

endmodule

// File: rtl/link_sample_sequencer.sv
// link_sample_sequencer: sample grid, ADC capture to link TX, and RX re-timing to DAC.
//   clock, reset          : system clock, synchronous active-high reset
//   enable                : run request
//   sync_in               : sender sync; SYNC_STABLE consecutive highs arm the grid
//   ad                    : ADC sample, captured on each tick
//   tx_data/valid/ready   : valid/ready handshake towards the link transmitter
//   rx_data/rx_valid      : received word and its one-cycle strobe
//   da                    : DAC sample, updated only on tick cycles
//   sync_out              : receiver path has produced data
//   sample_tick           : one-cycle pulse per grid point
//   overrun_cnt           : saturating count of TX words replaced before acceptance
//   state                 : current FSM state
module link_sample_sequencer
    import link_pkg::*;
#(
    parameter int SAMPLE_PERIOD = DEFAULT_SAMPLE_PERIOD,
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int SYNC_STABLE   = 4,
    parameter int OVR_CNT_WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     sync_in,
    input  logic [DATA_WIDTH-1:0]    ad,
    output logic [DATA_WIDTH-1:0]    tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    input  logic [DATA_WIDTH-1:0]    rx_data,
    input  logic                     rx_valid,
    output logic [DATA_WIDTH-1:0]    da,
    output logic                     sync_out,
    output logic                     sample_tick,
    output logic [OVR_CNT_WIDTH-1:0] overrun_cnt,
    output logic [1:0]               state
);

    localparam int SYNC_W = cnt_width(SYNC_STABLE + 1);
    // Value the counter holds on the cycle whose high sync_in completes the run.
    localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_STABLE - 1);

    link_state_t             state_reg;
    link_state_t             state_next;
    logic [SYNC_W-1:0]       sync_cnt_reg;
    logic [SYNC_W-1:0]       sync_cnt_next;
    logic                    tick;
    logic                    run;

    logic [DATA_WIDTH-1:0]    tx_data_reg;
    logic                     tx_valid_reg;
    logic [OVR_CNT_WIDTH-1:0] ovr_cnt_reg;

    logic [DATA_WIDTH-1:0]    rx_buf_reg;
    logic                     rx_full_reg;
    logic [DATA_WIDTH-1:0]    da_reg;
    logic                     sync_out_reg;

    // ---------------- FSM ----------------
    always_comb begin
        state_next    = state_reg;
        sync_cnt_next = '0;
        unique case (state_reg)
            ST_IDLE: begin
                if (enable) begin
                    state_next = ST_ARM;
                end
            end
            ST_ARM: begin
                if (!enable) begin
                    state_next = ST_IDLE;
                end else if (sync_in) begin
                    if (sync_cnt_reg == SYNC_LAST) begin
                        state_next = ST_RUN;
                    end else begin
                        sync_cnt_next = sync_cnt_reg + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Leave only once the last word has been handed over.
                if (!tx_valid_reg) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            sync_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            sync_cnt_reg <= sync_cnt_next;
        end
    end

    // ---------------- sample grid ----------------
    assign run = (state_reg == ST_RUN);

    sample_tick_gen #(
        .PERIOD (SAMPLE_PERIOD)
    ) u_tick_gen (
        .clock  (clock),
        .reset  (reset),
        .enable (run),
        .clear  (!run),
        .tick   (tick)
    );

    // ---------------- TX holding register ----------------
    // A tick always loads the new sample; if the old one was still unaccepted
    // it is lost and counted. With tx_ready high the old word goes out on the
    // same edge, so that is not an overrun.
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_data_reg  <= '0;
            tx_valid_reg <= 1'b0;
            ovr_cnt_reg  <= '0;
        end else if (tick) begin
            tx_data_reg  <= ad;
            tx_valid_reg <= 1'b1;
            if (tx_valid_reg && !tx_ready && (ovr_cnt_reg != '1)) begin
                ovr_cnt_reg <= ovr_cnt_reg + 1'b1;
            end
        end else if (tx_valid_reg && tx_ready) begin
            tx_valid_reg <= 1'b0;
        end
    end

    // ---------------- RX re-timer ----------------
    // The buffer is presented to da only on ticks, so da never changes
    // mid-period. A word arriving on the tick cycle itself waits for the next
    // tick (later assignment to rx_full_reg wins).
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_buf_reg   <= '0;
            rx_full_reg  <= 1'b0;
            da_reg       <= '0;
            sync_out_reg <= 1'b0;
        end else begin
            if (tick && rx_full_reg) begin
                da_reg       <= rx_buf_reg;
                sync_out_reg <= 1'b1;
                rx_full_reg  <= 1'b0;
            end
            if ((state_reg != ST_IDLE) && rx_valid) begin
                rx_buf_reg  <= rx_data;
                rx_full_reg <= 1'b1;
            end
            if ((state_reg == ST_DRAIN) && (state_next == ST_IDLE)) begin
                sync_out_reg <= 1'b0;
            end
        end
    end

    assign tx_data     = tx_data_reg;
    assign tx_valid    = tx_valid_reg;
    assign da          = da_reg;
    assign sync_out    = sync_out_reg;
    assign sample_tick = tick;
    assign overrun_cnt = ovr_cnt_reg;
    assign state       = state_reg;

endmodule

// File: tb/tb_link_sample_sequencer.sv
// Directed bench for link_sample_sequencer (SAMPLE_PERIOD=8, SYNC_STABLE=4,
// OVR_CNT_WIDTH=2). Inputs change and outputs are sampled 1 ns after each
// rising edge. A loopback feeds accepted TX words back into rx with a 3-cycle delay.
`timescale 1ns/1ps
module tb_link_sample_sequencer;

    localparam int P  = 8;
    localparam int DW = 8;
    localparam int SS = 4;
    localparam int OW = 2;

    logic          clock;
    logic          reset;
    logic          enable;
    logic          sync_in;
    logic [DW-1:0] ad;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic [DW-1:0] da;
    logic          sync_out;
    logic          sample_tick;
    logic [OW-1:0] overrun_cnt;
    logic [1:0]    state;

    int tests;
    int fails;

    // loopback delay line and handshake bookkeeping
    logic          lb_en;
    logic [2:0]    lb_v;
    logic [DW-1:0] lb_d0, lb_d1, lb_d2;
    int            accept_cnt;
    logic [DW-1:0] last_accept;

    link_sample_sequencer #(
        .SAMPLE_PERIOD (P),
        .DATA_WIDTH    (DW),
        .SYNC_STABLE   (SS),
        .OVR_CNT_WIDTH (OW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .sync_in     (sync_in),
        .ad          (ad),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .da          (da),
        .sync_out    (sync_out),
        .sample_tick (sample_tick),
        .overrun_cnt (overrun_cnt),
        .state       (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: note any handshake completing on this edge, then advance the loopback.
    task automatic step();
        logic          acc;
        logic [DW-1:0] w;
        acc = tx_valid && tx_ready;
        w   = tx_data;
        @(posedge clock);
        #1;
        if (acc) begin
            accept_cnt++;
            last_accept = w;
        end
        lb_v  = {lb_v[1:0], acc && lb_en};
        lb_d2 = lb_d1;
        lb_d1 = lb_d0;
        lb_d0 = w;
        rx_valid = lb_en && lb_v[2];
        rx_data  = lb_d2;
    endtask

    initial begin
        int acc_base;
        tests = 0; fails = 0;
        reset = 1'b1; enable = 1'b0; sync_in = 1'b0; ad = '0; tx_ready = 1'b0;
        rx_data = '0; rx_valid = 1'b0;
        lb_en = 1'b0; lb_v = '0; lb_d0 = '0; lb_d1 = '0; lb_d2 = '0;
        accept_cnt = 0; last_accept = '0;

        step(); step();
        check("rst_state", state, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_da", da, 0);
        check("rst_sync_out", sync_out, 0);
        check("rst_tick", sample_tick, 0);
        check("rst_ovr", overrun_cnt, 0);

        // ---- arm filter: 3 highs, 1 low, then 4 highs ----
        reset = 1'b0; enable = 1'b1;
        step(); check("arm_entry", state, 1);
        sync_in = 1'b1;
        for (int i = 0; i < 3; i++) begin step(); check("arm_hi3", state, 1); end
        sync_in = 1'b0;
        step(); check("arm_low", state, 1);
        sync_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); check("arm_hi4", state, 1); check("arm_no_tick", sample_tick, 0);
        end
        step(); check("run_entry", state, 2); check("first_tick", sample_tick, 1);

        // ---- TX handshake + loopback: ad 0x20..0x2F, one per tick ----
        tx_ready = 1'b1; lb_en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check("tick_period", sample_tick, 1);
            check("da_at_tick", da, (k >= 2) ? (32'h20 + k - 2) : 32'h0);
            check("sync_out_at_tick", sync_out, (k >= 2) ? 32'h1 : 32'h0);
            ad = 8'(32'h20 + k);
            step();
            $display("[TB] tick %0d ad=%02h tx_data=%02h tx_valid=%0b da=%02h sync_out=%0b",
                     k, ad, tx_data, tx_valid, da, sync_out);
            check("tx_valid_up", tx_valid, 1);
            check("tx_data", tx_data, 32'h20 + k);
            check("da_after_tick", da, (k >= 1) ? (32'h20 + k - 1) : 32'h0);
            check("tick_single", sample_tick, 0);
            step(); check("tx_valid_down", tx_valid, 0);
            for (int j = 0; j < 5; j++) begin
                step();
                check("no_mid_tick", sample_tick, 0);
                check("da_stable", da, (k >= 1) ? (32'h20 + k - 1) : 32'h0);
            end
            step();
        end
        check("ovr_none", overrun_cnt, 0);

        // ---- overrun: ready low across ticks with 0x31,0x32,0x33 ----
        lb_en = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0; ad = 8'h31;
        acc_base = accept_cnt;
        step(); check("ovr_load1", tx_data, 8'h31); check("ovr_ovr0", overrun_cnt, 0);
        repeat (7) step();
        check("ovr_tick2", sample_tick, 1); check("ovr_hold", tx_data, 8'h31);
        ad = 8'h32;
        step(); check("ovr_load2", tx_data, 8'h32); check("ovr_ovr1", overrun_cnt, 1);
        repeat (7) step();
        ad = 8'h33;
        step(); check("ovr_load3", tx_data, 8'h33); check("ovr_ovr2", overrun_cnt, 2);
        tx_ready = 1'b1;
        step(); check("ovr_drop_valid", tx_valid, 0);
        check("ovr_accept_once", accept_cnt - acc_base, 1);
        check("ovr_accept_word", last_accept, 8'h33);
        check("ovr_cnt_after", overrun_cnt, 2);
        repeat (6) step();

        // ---- saturation: five more dropped words with a 2-bit counter ----
        check("sat_tick0", sample_tick, 1);
        tx_ready = 1'b0; ad = 8'h40;
        step(); check("sat_start", overrun_cnt, 2);
        for (int j = 1; j <= 5; j++) begin
            repeat (7) step();
            check("sat_tick", sample_tick, 1);
            ad = 8'(32'h40 + j);
            step();
            check("sat_cnt", overrun_cnt, (2 + j > 3) ? 32'h3 : 32'(2 + j));
        end

        // ---- drain: enable drops with a word pending and ready low ----
        enable = 1'b0;
        step(); check("drain_state", state, 3); check("drain_sync_out", sync_out, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("drain_hold", state, 3);
            check("drain_no_tick", sample_tick, 0);
            check("drain_valid", tx_valid, 1);
            check("drain_data", tx_data, 8'h45);
        end
        tx_ready = 1'b1;
        step(); check("drain_accepted", tx_valid, 0);
        step(); check("drain_idle", state, 0); check("drain_sync_clr", sync_out, 0);
        check("idle_da_hold", da, 8'h2F);

        // ---- reset mid-RUN with a pending word ----
        tx_ready = 1'b0; enable = 1'b1;
        step(); check("rearm1", state, 1);
        repeat (3) step();
        step(); check("rerun_tick", sample_tick, 1);
        ad = 8'h55;
        step(); check("rerun_valid", tx_valid, 1); check("rerun_data", tx_data, 8'h55);
        reset = 1'b1;
        step();
        check("mid_rst_state", state, 0);
        check("mid_rst_valid", tx_valid, 0);
        check("mid_rst_data", tx_data, 0);
        check("mid_rst_da", da, 0);
        check("mid_rst_ovr", overrun_cnt, 0);
        check("mid_rst_tick", sample_tick, 0);
        reset = 1'b0;
        step(); check("rearm2", state, 1);
        for (int i = 0; i < 3; i++) begin step(); check("rearm2_arm", state, 1); end
        step(); check("rearm2_run", state, 2); check("rearm2_tick", sample_tick, 1);
        for (int i = 0; i < 7; i++) begin step(); check("rearm2_gap", sample_tick, 0); end
        step(); check("rearm2_tick2", sample_tick, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
